// File: rtl/button_pkg.sv
// button_pkg: shared timing constants, channel state type and counter sizing for button conditioning.
package button_pkg;
   localparam int CLK_HZ        = 50_000_000;
   localparam int DEBOUNCE_20MS = CLK_HZ / 1000 * 20;
   localparam int REPEAT_500MS  = CLK_HZ / 1000 * 500;
   localparam int REPEAT_100MS  = CLK_HZ / 1000 * 100;

   typedef enum logic [1:0] {IDLE, WAIT_DELAY, REPEATING} state_t;

   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return $clog2(m) + 1;
   endfunction
endpackage

// File: rtl/button_channel.sv
// button_channel: one button's synchronizer, debounce, press/release pulses and auto-repeat.
// Auto-repeat is built only when BUTTON_REPEAT_EN is defined.
module button_channel
   import button_pkg::*;
#(
   parameter int STABLE_CYCLES = DEBOUNCE_20MS,
   parameter int REPEAT_DELAY  = REPEAT_500MS,
   parameter int REPEAT_PERIOD = REPEAT_100MS
) (
   input  logic clk,
   input  logic rst,
   input  logic pb,
   output logic held,
   output logic press,
   output logic release_pulse
);
   localparam int CW = cnt_width(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

   logic          s1, s2;
   logic [CW-1:0] cnt;
   logic          accept, rise, fall, rep;

   assign accept = (s2 != held) && (cnt == CW'(STABLE_CYCLES - 1));
   assign rise   = accept & s2;
   assign fall   = accept & ~s2;

   // any sample equal to held restarts the stability count
   always_ff @(posedge clk) begin
      if (rst) begin
         s1            <= 1'b0;
         s2            <= 1'b0;
         cnt           <= '0;
         held          <= 1'b0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         s1            <= pb;
         s2            <= s1;
         cnt           <= (s2 == held || accept) ? '0 : cnt + CW'(1);
         held          <= accept ? s2 : held;
         press         <= rise | rep;
         release_pulse <= fall;
      end
   end

`ifdef BUTTON_REPEAT_EN
   state_t        state, state_n;
   logic [CW-1:0] rpt, rpt_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rpt   <= '0;
      end else begin
         state <= state_n;
         rpt   <= rpt_n;
      end
   end

   // a falling held overrides any repeat expiring in the same cycle
   always_comb begin
      state_n = state;
      rpt_n   = rpt + CW'(1);
      rep     = 1'b0;
      if (fall) begin
         state_n = IDLE;
         rpt_n   = '0;
      end else begin
         case (state)
            IDLE: begin
               rpt_n   = '0;
               state_n = rise ? WAIT_DELAY : IDLE;
            end
            WAIT_DELAY: if (rpt == CW'(REPEAT_DELAY - 1)) begin
               state_n = REPEATING;
               rpt_n   = '0;
               rep     = 1'b1;
            end
            REPEATING: if (rpt == CW'(REPEAT_PERIOD - 1)) begin
               rpt_n = '0;
               rep   = 1'b1;
            end
            default: begin
               state_n = IDLE;
               rpt_n   = '0;
            end
         endcase
      end
   end
`else
   assign rep = 1'b0;
`endif
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: WIDTH independent button channels (sync, debounce, pulses, optional repeat).
// Auto-repeat is enabled by defining BUTTON_REPEAT_EN.
module button_conditioner
   import button_pkg::*;
#(
   parameter int WIDTH         = 4,
   parameter int STABLE_CYCLES = DEBOUNCE_20MS,
   parameter int REPEAT_DELAY  = REPEAT_500MS,
   parameter int REPEAT_PERIOD = REPEAT_100MS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pb,
   output logic [WIDTH-1:0] held,
   output logic [WIDTH-1:0] press,
   output logic [WIDTH-1:0] release_pulse
);
   genvar g;
   generate
      for (g = 0; g < WIDTH; g++) begin : g_ch
         button_channel #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
         ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .pb           (pb[g]),
            .held         (held[g]),
            .press        (press[g]),
            .release_pulse(release_pulse[g])
         );
      end
   endgenerate
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: randomized and directed checks against a sample-window reference model.
module tb_button_conditioner;
   localparam int W  = 4;
   localparam int S  = 4;
   localparam int RD = 10;
   localparam int RP = 3;
`ifdef BUTTON_REPEAT_EN
   localparam bit REP_ON = 1'b1;
`else
   localparam bit REP_ON = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] pb  = '0;
   logic [W-1:0] held, press, rel;

   logic [W-1:0] hist [0:S];
   logic [W-1:0] mh, mp, mr;
   int           age [W];
   int           checks = 0;
   int           errors = 0;

   button_conditioner #(
      .WIDTH(W), .STABLE_CYCLES(S), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk), .rst(rst), .pb(pb), .held(held), .press(press), .release_pulse(rel)
   );

   always #5 clk = ~clk;

   // Model: held flips once the last S synchronized samples all disagree with it;
   // repeats fire at RD, RD+RP, RD+2RP... cycles after the press while still held.
   task automatic cyc();
      logic all_diff;
      if (rst) begin
         for (int k = 0; k <= S; k++) hist[k] = '0;
         mh = '0; mp = '0; mr = '0;
         for (int c = 0; c < W; c++) age[c] = 0;
      end else begin
         for (int c = 0; c < W; c++) begin
            mp[c] = 1'b0;
            mr[c] = 1'b0;
            all_diff = 1'b1;
            for (int k = 1; k <= S; k++) if (hist[k][c] == mh[c]) all_diff = 1'b0;
            if (all_diff) begin
               mh[c]  = ~mh[c];
               age[c] = 0;
               if (mh[c]) mp[c] = 1'b1; else mr[c] = 1'b1;
            end else if (mh[c]) begin
               age[c]++;
               if (REP_ON && age[c] >= RD && (age[c] - RD) % RP == 0) mp[c] = 1'b1;
            end
         end
         for (int k = S; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = pb;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; pb = 4'hF;
      for (int i = 1; i <= 3; i++) begin
         cyc();
         checks++;
         if ({held, press, rel} !== 12'h000) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d held=%h press=%h release=%h required all 0", i, held, press, rel);
         end
      end
      rst = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         cyc();
         checks++;
         if (press !== ((i == 6) ? 4'hF : 4'h0)) begin
            errors++;
            $display("FAIL reset_press cyc=%0d press=%h required %h", i, press, (i == 6) ? 4'hF : 4'h0);
         end
         checks++;
         if ({held, press, rel} !== {mh, mp, mr}) begin
            errors++;
            $display("FAIL reset_model cyc=%0d held=%h/%h press=%h/%h release=%h/%h", i, held, mh, press, mp, rel, mr);
         end
      end
      pb = 4'h0;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         checks++;
         if ({held, press, rel} !== {mh, mp, mr}) begin
            errors++;
            $display("FAIL reset_settle cyc=%0d held=%h/%h press=%h/%h release=%h/%h", i, held, mh, press, mp, rel, mr);
         end
      end
   endtask

   task automatic test_bounce();
      logic pat [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
      int   np = 0;
      for (int i = 0; i < 17; i++) begin
         pb[0] = (i < 9) ? pat[i] : 1'b1;
         cyc();
         np += int'(press[0]);
         checks++;
         if ({held, press, rel} !== {mh, mp, mr}) begin
            errors++;
            $display("FAIL bounce_model cyc=%0d held=%h/%h press=%h/%h release=%h/%h", i, held, mh, press, mp, rel, mr);
         end
      end
      checks++;
      if (np !== 1 || held[0] !== 1'b1) begin
         errors++;
         $display("FAIL bounce_count presses=%0d held0=%b required 1 and 1", np, held[0]);
      end
   endtask

   task automatic test_release();
      int nr = 0, rc = 0;
      pb[0] = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         cyc();
         if (rel[0]) begin nr++; rc = i; end
         checks++;
         if (rel[0] && press[0]) begin
            errors++;
            $display("FAIL release_overlap cyc=%0d press0=1 required 0", i);
         end
         checks++;
         if ({held, press, rel} !== {mh, mp, mr}) begin
            errors++;
            $display("FAIL release_model cyc=%0d held=%h/%h press=%h/%h release=%h/%h", i, held, mh, press, mp, rel, mr);
         end
      end
      checks++;
      if (nr !== 1 || rc !== 6) begin
         errors++;
         $display("FAIL release_timing count=%0d cycle=%0d required 1 at 6", nr, rc);
      end
   endtask

   task automatic test_repeat();
      int q[$], eq[$], npost = 0, nrel = 0, relc = 0;
      if (REP_ON) eq = '{6, 16, 19, 22, 25}; else eq = '{6};
      pb[1] = 1'b1;
      for (int i = 1; i <= 25; i++) begin
         cyc();
         if (press[1]) q.push_back(i);
         checks++;
         if ({held, press, rel} !== {mh, mp, mr}) begin
            errors++;
            $display("FAIL repeat_model cyc=%0d held=%h/%h press=%h/%h release=%h/%h", i, held, mh, press, mp, rel, mr);
         end
      end
      checks++;
      if (q.size() != eq.size()) begin
         errors++;
         $display("FAIL repeat_count presses=%0d required %0d", q.size(), eq.size());
      end else begin
         foreach (eq[k]) begin
            checks++;
            if (q[k] !== eq[k]) begin
               errors++;
               $display("FAIL repeat_time idx=%0d cycle=%0d required %0d", k, q[k], eq[k]);
            end
         end
      end
      pb[1] = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         cyc();
         if (rel[1]) begin nrel++; relc = i; end
         if (relc != 0 && press[1]) npost++;
         checks++;
         if ({held, press, rel} !== {mh, mp, mr}) begin
            errors++;
            $display("FAIL repeat_drop_model cyc=%0d held=%h/%h press=%h/%h release=%h/%h", i, held, mh, press, mp, rel, mr);
         end
      end
      checks++;
      if (nrel !== 1 || relc !== 6 || npost !== 0) begin
         errors++;
         $display("FAIL repeat_release releases=%0d at %0d later_presses=%0d required 1 at 6 and 0", nrel, relc, npost);
      end
   endtask

   task automatic test_independent();
      int c2 = 0, c3 = 0, n2 = 0, n3 = 0;
      for (int i = 1; i <= 14; i++) begin
         pb[2] = 1'b1;
         pb[3] = (i != 2);
         cyc();
         if (press[2]) begin n2++; c2 = i; end
         if (press[3]) begin n3++; c3 = i; end
         checks++;
         if ({held, press, rel} !== {mh, mp, mr}) begin
            errors++;
            $display("FAIL indep_model cyc=%0d held=%h/%h press=%h/%h release=%h/%h", i, held, mh, press, mp, rel, mr);
         end
      end
      checks++;
      if (n2 !== 1 || n3 !== 1 || c2 !== 6 || c3 !== 8) begin
         errors++;
         $display("FAIL indep_order p2=%0d@%0d p3=%0d@%0d required 1@6 1@8", n2, c2, n3, c3);
      end
      pb[3:2] = 2'b00;
      for (int i = 1; i <= 12; i++) begin
         cyc();
         checks++;
         if ({held, press, rel} !== {mh, mp, mr}) begin
            errors++;
            $display("FAIL indep_drop cyc=%0d held=%h/%h press=%h/%h release=%h/%h", i, held, mh, press, mp, rel, mr);
         end
      end
   endtask

   task automatic test_reset_mid();
      pb[1] = 1'b1;
      for (int i = 1; i <= 20; i++) cyc();
      rst = 1'b1;
      cyc();
      checks++;
      if ({held, press, rel} !== 12'h000) begin
         errors++;
         $display("FAIL midrst_clear held=%h press=%h release=%h required all 0", held, press, rel);
      end
      rst = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         cyc();
         checks++;
         if (press[1] !== (i == 6)) begin
            errors++;
            $display("FAIL midrst_press cyc=%0d press1=%b required %b", i, press[1], i == 6);
         end
         checks++;
         if ({held, press, rel} !== {mh, mp, mr}) begin
            errors++;
            $display("FAIL midrst_model cyc=%0d held=%h/%h press=%h/%h release=%h/%h", i, held, mh, press, mp, rel, mr);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 1; i <= 1500; i++) begin
         for (int c = 0; c < W; c++) if ($urandom_range(15) == 0) pb[c] = ~pb[c];
         rst = ($urandom_range(299) == 0);
         cyc();
         checks++;
         if ({held, press, rel} !== {mh, mp, mr}) begin
            errors++;
            $display("FAIL random_model cyc=%0d held=%h/%h press=%h/%h release=%h/%h", i, held, mh, press, mp, rel, mr);
         end
         checks++;
         if ((press & rel) !== 4'h0) begin
            errors++;
            $display("FAIL random_overlap cyc=%0d press&release=%h required 0", i, press & rel);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_release();
      test_repeat();
      test_independent();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
